slow_clk_deser: RTL and testbench

// - Downstream consumer of the clock manager's slow clock (clk_2 at 10 Hz..78.125 mHz): samples it in the
//   100 MHz reference domain, turns each rising edge into a 1-cycle tick and shifts one serial bit per tick.
// - Assembles WIDTH-bit words MSB-first and offers each word with a ready/ack handshake to the next stage.
// - Word rate therefore follows the clock manager's programmed mode; no second clock domain inside.

---
 rtl/slow_clk_deser_pkg.sv | 8 +
 rtl/slow_clk_deser_sync_edge_det.sv | 31 +++
 rtl/slow_clk_deser.sv | 67 ++++++
 tb/tb_slow_clk_deser.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/slow_clk_deser_pkg.sv
// slow_clk_deser_pkg: shared state encoding and sizing helpers for clock-manager consumers
package slow_clk_deser_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, HOLD = 2'd2} state_t;
  localparam int DEF_SYNC_STAGES = 2;
  function automatic int cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction
endpackage

// File: rtl/slow_clk_deser_sync_edge_det.sv
// sync_edge_det: multi-flop synchroniser with registered rising-edge pulse
module sync_edge_det
  import slow_clk_deser_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);
  logic [STAGES-1:0] s, v;
  logic q_d, armed;
  // armed only after a genuine low sample, so an input already high out of reset never pulses
  always_ff @(posedge clk)
    if (rst) begin
      s <= '0;
      v <= '0;
      q_d <= 1'b0;
      armed <= 1'b0;
      rise <= 1'b0;
    end else begin
      s <= {s[STAGES-2:0], d};
      v <= {v[STAGES-2:0], 1'b1};
      q_d <= s[STAGES-1];
      armed <= armed | (v[STAGES-1] & ~s[STAGES-1]);
      rise <= s[STAGES-1] & ~q_d & armed;
    end
  assign q = s[STAGES-1];
endmodule

// File: rtl/slow_clk_deser.sv
// slow_clk_deser: deserialises data_in on synchronised clk_slow rising edges into handshaked words
module slow_clk_deser
  import slow_clk_deser_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  localparam int CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_slow,
  input  logic             data_in,
  input  logic             enable,
  output logic [WIDTH-1:0] data_out,
  output logic             data_ready,
  input  logic             ack_in,
  output logic             overrun,
  output logic [CNT_W-1:0] bit_cnt
);
  state_t st;
  logic [WIDTH-1:0] shift;
  logic tick, data_sync, unused_slow_q, unused_rise;
  wire [WIDTH-1:0] nxt = {shift[WIDTH-2:0], data_sync};
  sync_edge_det #(.STAGES(SYNC_STAGES)) u_clk (
    .clk(clk), .rst(rst), .d(clk_slow), .q(unused_slow_q), .rise(tick)
  );
  sync_edge_det #(.STAGES(SYNC_STAGES)) u_dat (
    .clk(clk), .rst(rst), .d(data_in), .q(data_sync), .rise(unused_rise)
  );
  always_ff @(posedge clk)
    if (rst) begin
      st <= IDLE;
      shift <= '0;
      bit_cnt <= '0;
      data_out <= '0;
      data_ready <= 1'b0;
      overrun <= 1'b0;
    end else
      case (st)
        IDLE: if (enable) begin
          st <= COLLECT;
          shift <= '0;
          bit_cnt <= '0;
        end
        COLLECT:
          if (!enable) begin
            st <= IDLE;
            shift <= '0;
            bit_cnt <= '0;
          end else if (tick) begin
            shift <= nxt;
            bit_cnt <= (bit_cnt == CNT_W'(WIDTH - 1)) ? '0 : bit_cnt + 1'b1;
            if (bit_cnt == CNT_W'(WIDTH - 1)) begin
              data_out <= nxt;
              data_ready <= 1'b1;
              st <= HOLD;
            end
          end
        HOLD:
          if (ack_in) begin
            data_ready <= 1'b0;
            overrun <= 1'b0;
            st <= enable ? COLLECT : IDLE;
          end else if (tick) overrun <= 1'b1;
        default: st <= IDLE;
      endcase
endmodule

// File: tb/tb_slow_clk_deser.sv
// tb_slow_clk_deser: scoreboard bench for slow_clk_deser word assembly, handshake and abort paths
module tb_slow_clk_deser;
  logic clk = 0, rst = 1, clk_slow = 0, data_in = 0, enable = 0, ack_in = 0;
  logic [7:0] data_out;
  logic data_ready, overrun;
  logic [3:0] bit_cnt;
  int checks = 0, errors = 0;
  logic [7:0] sb[$];
  logic rdy_d = 0;

  slow_clk_deser #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .clk_slow(clk_slow), .data_in(data_in), .enable(enable),
    .data_out(data_out), .data_ready(data_ready), .ack_in(ack_in), .overrun(overrun),
    .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_ready && !rdy_d) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word data_out=%h with empty scoreboard", data_out);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if (data_out !== e) begin
          errors++;
          $display("FAIL word data_out=%h expected=%h", data_out, e);
        end
      end
    end
    rdy_d = data_ready;
  end

  task automatic half_period(input logic lvl);
    @(posedge clk); #1 clk_slow = lvl;
    repeat (49) @(posedge clk);
  endtask

  task automatic send_bit(input logic b);
    @(posedge clk); #1 begin clk_slow = 1; data_in = b; end
    repeat (49) @(posedge clk);
    half_period(1'b0);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic do_ack();
    @(posedge clk); #1 ack_in = 1;
    @(posedge clk); #1 ack_in = 0;
    @(negedge clk);
    checks++;
    if (data_ready !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL ack_clear ready=%b overrun=%b expected 0 0", data_ready, overrun);
    end
  endtask

  task automatic settle();
    clk_slow = 0;
    repeat (10) @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1; enable = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (c == 3) rst = 0;
      if (c % 25 == 0) clk_slow = ~clk_slow;
      @(negedge clk);
      checks++;
      if (data_ready !== 1'b0 || bit_cnt !== 4'd0 || data_out !== 8'd0 || overrun !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle c=%0d ready=%b cnt=%0d out=%h ovr=%b expected 0", c, data_ready, bit_cnt, data_out, overrun);
      end
    end
    settle();
  endtask

  task automatic test_basic();
    logic [7:0] w;
    w = 8'hA5;
    enable = 1;
    sb.push_back(w);
    for (int i = 7; i >= 1; i--) send_bit(w[i]);
    @(posedge clk); #1 begin clk_slow = 1; data_in = w[0]; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (data_ready !== 1'b0) begin
      errors++;
      $display("FAIL latency_early ready=%b expected 0 at 3 cycles", data_ready);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (data_ready !== 1'b1 || bit_cnt !== 4'd0) begin
      errors++;
      $display("FAIL latency_ready ready=%b cnt=%0d expected 1 0 at 4 cycles", data_ready, bit_cnt);
    end
    repeat (45) @(posedge clk);
    half_period(1'b0);
    do_ack();
  endtask

  task automatic test_overrun();
    sb.push_back(8'h3C);
    send_word(8'h3C);
    send_bit(1'b1);
    @(negedge clk);
    checks++;
    if (overrun !== 1'b1 || data_out !== 8'h3C || data_ready !== 1'b1) begin
      errors++;
      $display("FAIL overrun ovr=%b out=%h ready=%b expected 1 3c 1", overrun, data_out, data_ready);
    end
    do_ack();
    sb.push_back(8'hF0);
    send_word(8'hF0);
    checks++;
    if (overrun !== 1'b0 || data_out !== 8'hF0) begin
      errors++;
      $display("FAIL after_overrun ovr=%b out=%h expected 0 f0", overrun, data_out);
    end
    do_ack();
  endtask

  task automatic test_collision();
    sb.push_back(8'h5A);
    send_word(8'h5A);
    @(posedge clk); #1 begin clk_slow = 1; data_in = 1; end
    repeat (3) @(posedge clk);
    #1 ack_in = 1;
    @(posedge clk); #1 ack_in = 0;
    @(negedge clk);
    checks++;
    if (overrun !== 1'b0 || data_ready !== 1'b0 || bit_cnt !== 4'd0) begin
      errors++;
      $display("FAIL collision ovr=%b ready=%b cnt=%0d expected 0 0 0", overrun, data_ready, bit_cnt);
    end
    repeat (45) @(posedge clk);
    half_period(1'b0);
    checks++;
    if (bit_cnt !== 4'd0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL collision_drop cnt=%0d ovr=%b expected 0 0", bit_cnt, overrun);
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    checks++;
    if (bit_cnt !== 4'd5) begin
      errors++;
      $display("FAIL abort_partial cnt=%0d expected 5", bit_cnt);
    end
    @(posedge clk); #1 enable = 0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (bit_cnt !== 4'd0 || data_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_clear cnt=%0d ready=%b expected 0 0", bit_cnt, data_ready);
    end
    #1 enable = 1;
    sb.push_back(8'h81);
    send_word(8'h81);
    checks++;
    if (data_out !== 8'h81 || data_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_reenable out=%h ready=%b expected 81 1", data_out, data_ready);
    end
    do_ack();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    checks++;
    if (bit_cnt !== 4'd4) begin
      errors++;
      $display("FAIL mid_partial cnt=%0d expected 4", bit_cnt);
    end
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    checks++;
    if (bit_cnt !== 4'd0 || data_ready !== 1'b0 || data_out !== 8'd0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset cnt=%0d ready=%b out=%h ovr=%b expected 0", bit_cnt, data_ready, data_out, overrun);
    end
    settle();
    sb.push_back(8'hC3);
    send_word(8'hC3);
    send_bit(1'b0);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    checks++;
    if (bit_cnt !== 4'd0 || data_ready !== 1'b0 || data_out !== 8'd0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL hold_reset cnt=%0d ready=%b out=%h ovr=%b expected 0", bit_cnt, data_ready, data_out, overrun);
    end
    enable = 0;
    repeat (200) @(posedge clk);
    @(negedge clk);
    checks++;
    if (data_ready !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL end_state ready=%b pending=%0d expected 0 0", data_ready, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_collision();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
